gray_ptr_decoder: RTL
=====================

Name: gray_ptr_decoder

Overview:
Receive end of the team's binary-to-Gray encoding path. Takes a Gray-coded pointer or count launched from another clock domain and synchronises it into clk. Decodes it to binary and reports per-cycle step size and protocol violations (more than one bit changed between samples). Sits in front of async-FIFO full/empty logic and cross-domain counters.

Parameters:
WIDTH, 4, pointer width in bits (>=2)
SYNC_STAGES, 2, synchroniser flops per bit (>=2)

Ports:
clk  input  1  single clock for all logic
resetn  input  1  asynchronous active-low reset, synchronously deasserted upstream
gray_in  input  WIDTH  Gray-coded value from foreign domain, asynchronous to clk
clear_err  input  1  synchronous clear of err_sticky
binary_out  output  WIDTH  decoded binary value, registered
bin_valid  output  1  binary_out holds a real sample (priming complete)
changed  output  1  one-cycle pulse: decoded value differs from previous sample
delta  output  WIDTH  (new_bin - prev_bin) mod 2^WIDTH for the current sample, registered
step_err  output  1  one-cycle pulse: Hamming distance between consecutive synced Gray samples > 1
err_sticky  output  1  set by step_err, held until clear_err

Behaviour:
- Reset (resetn low, async): all sync flops, g_prev, binary_out and delta go to 0. bin_valid, changed, step_err and err_sticky go to 0. State goes to FILL; fill counter goes to 0.
- Sync chain: sync[0] <= gray_in; sync[i] <= sync[i-1]. g_sync = sync[SYNC_STAGES-1]. No logic between stages.
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i]. Combinational on g_sync, registered into binary_out.
- Latency: a gray_in value stable before edge k appears on binary_out after edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 edges.
- FSM: FILL -> PRIME -> TRACK.
  - FILL: lasts SYNC_STAGES cycles after reset release (counter 0..SYNC_STAGES-1). All outputs hold reset values.
  - PRIME: one cycle. binary_out <= bin(g_sync); g_prev <= g_sync; bin_valid <= 1; delta <= 0. No changed/step_err. Next state TRACK.
  - TRACK: every cycle, g_prev <= g_sync; binary_out <= bin(g_sync); delta <= bin(g_sync) - bin(g_prev) (WIDTH-bit wrap).
    - changed <= (g_sync != g_prev).
    - step_err <= popcount(g_sync ^ g_prev) > 1.
    - TRACK is terminal until reset.
- bin_valid rises on the edge SYNC_STAGES+1 after reset release and stays 1 until reset.
- Wrap-around: max -> 0 (e.g. gray 1000 -> 0000 at WIDTH=4) is a legal single-bit step with delta = 1. A backward step (0001 -> 0000) is legal with delta = 2^WIDTH-1.
- Error step: outputs still update to the new decoded value; delta reports the raw modular difference; step_err pulses.
- err_sticky: set on any cycle step_err is being asserted. clear_err clears it. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: immediate return to reset values and FILL. A new priming sequence follows; no error is reported for the jump across reset.
- Hold (no input change): changed=0, delta=0, step_err=0.

Decomposition:
- Shared package gray_pkg:
  - function gray2bin(WIDTH-generic via parameterised width or max width);
  - function popcount;
  - enum state_t {FILL, PRIME, TRACK}.
- One natural sub-module: bit_sync (SYNC_STAGES-deep flop chain on a WIDTH-wide bus, async active-low reset to 0), instantiated once.
- Decode, compare and FSM stay in gray_ptr_decoder.

Test Plan:
- Priming: release resetn with gray_in=0110 held -> bin_valid 0 for 2 edges, rises on 3rd edge with binary_out=0100, changed=0, step_err=0, delta=0.
- Full sweep: after priming, drive gray(i) for i=0..15 one per cycle, then 0 again -> binary_out = i three edges later, delta=1 and changed=1 every cycle including 15->0 (gray 1000->0000), no step_err.
- Backward/hold: drive 0001, 0001, 0000 -> changed 1,0,1; delta 1,0,15; no step_err.
- Illegal jump: from 0000 drive 0011 -> binary_out=0010, delta=2, step_err one-cycle pulse, err_sticky=1 and held for following idle cycles.
- Clear priority: assert clear_err in the same cycle step_err fires (0011->0000) -> err_sticky stays 1. clear_err alone on the next cycle -> err_sticky=0.
- Reset mid-sweep: pulse resetn low asynchronously between edges while at value 9 -> all outputs 0 immediately. After release with gray_in=1111, bin_valid returns after 3 edges with binary_out=1010 and no step_err.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-pointer receive path.
package gray_pkg;

   // Widest pointer the generic helpers handle; callers zero-extend into
   // this width and truncate the result back to their own width.
   localparam int unsigned MAX_W = 64;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      PRIME = 2'd1,
      TRACK = 2'd2
   } state_t;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   // Zero-extended upper bits decode to zero, so truncation is exact.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b[MAX_W-1] = g[MAX_W-1];
      for (int i = int'(MAX_W) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Number of set bits.
   function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < int'(MAX_W); i++) begin
         n = n + {31'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-stage flop chain that brings a foreign-domain bus into clk.
// Pure flops between stages so each bit resolves metastability independently.
module bit_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;

   // Shift the bus one stage per clock; stage 0 samples the asynchronous input.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_decoder.sv
// Receive end of a Gray-coded pointer crossing: synchronise, decode to binary,
// and report step size, change pulses and multi-bit-step violations.
module gray_ptr_decoder
   import gray_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             clear_err,
   output logic [WIDTH-1:0] binary_out,
   output logic             bin_valid,
   output logic             changed,
   output logic [WIDTH-1:0] delta,
   output logic             step_err,
   output logic             err_sticky
);

   localparam int CNT_W = (SYNC_STAGES > 2) ? $clog2(SYNC_STAGES) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] fill_cnt;
   logic [WIDTH-1:0] g_sync;
   logic [WIDTH-1:0] g_prev;
   logic [WIDTH-1:0] bin_cur;
   logic             step_bad;
   logic             sticky_set;

   bit_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (gray_in),
      .q      (g_sync)
   );

   // In TRACK, binary_out always equals the decode of g_prev, so the delta
   // can subtract binary_out instead of decoding g_prev a second time.
   assign bin_cur    = WIDTH'(gray2bin(MAX_W'(g_sync)));
   assign step_bad   = popcount(MAX_W'(g_sync ^ g_prev)) > 1;
   assign sticky_set = (state == TRACK) && step_bad;

   // Next-state: wait for the synchroniser to flush, take one priming sample, then track forever.
   always_comb begin
      state_nxt = state;
      unique case (state)
         FILL:    if (fill_cnt == CNT_W'(SYNC_STAGES - 1)) state_nxt = PRIME;
         PRIME:   state_nxt = TRACK;
         TRACK:   state_nxt = TRACK;
         default: state_nxt = FILL;
      endcase
   end

   // State register and fill counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= FILL;
         fill_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == FILL) fill_cnt <= fill_cnt + 1'b1;
      end
   end

   // Registered outputs: prime on the first real sample, then compare each sample with the last.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         g_prev     <= '0;
         binary_out <= '0;
         delta      <= '0;
         bin_valid  <= 1'b0;
         changed    <= 1'b0;
         step_err   <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         changed  <= 1'b0;
         step_err <= 1'b0;
         unique case (state)
            PRIME: begin
               g_prev     <= g_sync;
               binary_out <= bin_cur;
               bin_valid  <= 1'b1;
               delta      <= '0;
            end
            TRACK: begin
               g_prev     <= g_sync;
               binary_out <= bin_cur;
               delta      <= bin_cur - binary_out;
               changed    <= (g_sync != g_prev);
               step_err   <= step_bad;
            end
            default: ;
         endcase
         // A new error beats a simultaneous clear.
         err_sticky <= sticky_set | (err_sticky & ~clear_err);
      end
   end

endmodule
